// File: rtl/btn_debounce_chan.sv
// One input channel: 2-flop synchronizer, tick-based stability debounce
// and registered rise/fall pulses aligned with the level change.
module debounce_chan #(
    parameter int STABLE_TICKS = 10,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync_meta_r;
    logic             sync_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             rise_r;
    logic             fall_r;

    // Synchronize, count stable ticks, and accept the new value with an edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            sync_q_r    <= 1'b0;
            cnt_r       <= '0;
            level_r     <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
        end else begin
            sync_meta_r <= raw;
            sync_q_r    <= sync_meta_r;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            if (sync_q_r == level_r) begin
                // any bounce back to the accepted level restarts the count
                cnt_r <= '0;
            end else if (tick && (cnt_r == CNT_LAST)) begin
                level_r <= sync_q_r;
                cnt_r   <= '0;
                rise_r  <= sync_q_r;
                fall_r  <= ~sync_q_r;
            end else if (tick) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: shared debounce prescaler, per-channel
// debounce, and a pending press mask drained lowest-index-first.
module btn_debounce #(
    parameter int  WIDTH        = 16,
    parameter int  TICK_DIV     = 50000,
    parameter int  STABLE_TICKS = 10,
    localparam int IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             overflow
);
    localparam int               CNT_W    = $clog2(STABLE_TICKS + 1);
    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] pend_next_s;
    logic [WIDTH-1:0] pop_mask_s;
    logic [IDX_W-1:0] idx_s;
    logic             pop_s;
    logic             ovf_set_s;
    logic             ovf_r;

    // Debounce tick prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    assign tick_s = (pre_r == PRE_LAST);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_chan
            debounce_chan #(
                .STABLE_TICKS(STABLE_TICKS),
                .CNT_W       (CNT_W)
            ) u_chan (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw_in[g]),
                .tick (tick_s),
                .level(level[g]),
                .rise (rise[g]),
                .fall (fall[g])
            );
        end
    endgenerate

    // Lowest-set-bit priority encoder over the pending mask
    always_comb begin
        idx_s = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_r[i]) begin
                idx_s = IDX_W'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign evt_valid = |pend_r;
    assign evt_idx   = idx_s;
    assign pop_s     = evt_valid & evt_ready;

    // Pending update: a new press outranks a pop of the same bit
    always_comb begin
        pop_mask_s = '0;
        if (pop_s) begin
            pop_mask_s[idx_s] = 1'b1;
        end else begin
            pop_mask_s = '0;
        end
        pend_next_s = (pend_r & ~pop_mask_s) | rise;
        ovf_set_s   = |(rise & pend_r & ~pop_mask_s);
    end

    // Pending mask and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            pend_r <= pend_next_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign overflow = ovf_r;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side counterpart to the LED output drivers: conditions raw board buttons/switches into clean levels and press events for the rest of the design.
- Per channel: 2-FF synchronizer, tick-based stability debounce, rise/fall pulses.
- Press events are buffered in a pending mask and drained lowest-index-first over a valid/ready handshake.

Parameters:
- WIDTH, 16, number of input channels.
- TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be >= 2.
- STABLE_TICKS, 10, ticks a new input value must persist before it is accepted; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- raw_in  in  WIDTH  asynchronous raw button/switch inputs.
- level  out  WIDTH  debounced levels.
- rise  out  WIDTH  one-cycle pulse per channel on a debounced 0->1 change.
- fall  out  WIDTH  one-cycle pulse per channel on a debounced 1->0 change.
- evt_valid  out  1  at least one press event is pending.
- evt_idx  out  IDX_W  index of the lowest pending channel (IDX_W = clog2(WIDTH), minimum 1).
- evt_ready  in  1  consumer accepts the event.
- ovf_clr  in  1  clears overflow.
- overflow  out  1  sticky flag: a press was lost.

Behaviour:
- Reset: while rst=1, all registers are 0 at the next edge. This includes the sync flops, prescaler, channel counters, level, rise, fall, pending mask and overflow. After reset, level=0 regardless of raw_in.
- Reset mid-debounce: discards partial progress. An input held high across reset produces a fresh rise after the full debounce latency.
- Synchronizer: 2 flops per bit; sync_q is the output of the second flop.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when the count equals TICK_DIV-1.
- Channel counter (width clog2(STABLE_TICKS+1)), evaluated every cycle:
  - if sync_q[i]==level[i]: cnt<=0 (any bounce back restarts the count).
  - else if tick and cnt==STABLE_TICKS-1: level[i]<=sync_q[i], cnt<=0.
  - else if tick: cnt<=cnt+1.
- Latency from a raw change to a level change: between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV cycles.
- rise/fall: registered. They are high in exactly the cycle in which the new level is first visible; otherwise 0. rise and fall are never both high on the same channel.
- Pending mask pend (WIDTH bits):
  - evt_valid = |pend.
  - evt_idx = index of the lowest set bit; 0 when pend=0.
  - pop = evt_valid & evt_ready; pop clears pend[evt_idx].
  - rise[i] sets pend[i].
  - If set and pop hit the same bit in the same cycle, set wins: the bit stays 1 and there is no overflow.
  - If rise[i] arrives while pend[i]=1 and that bit is not being popped this cycle: pend stays 1 and overflow<=1.
- Falls never create events.
- evt_idx and evt_valid are stable while evt_valid=1 and evt_ready=0, except that a new lower-index press may preempt evt_idx.
- Overflow is sticky and cleared only by ovf_clr or rst. If ovf_clr and a new overflow occur in the same cycle, the set wins.
- Simultaneous rises on several channels all set their bits in the same cycle.

Decomposition:
- No shared package. IDX_W and CNT_W are localparams computed from the parameters.
- One sub-module, debounce_chan: sync flops, counter, level, rise and fall for one bit, with tick as an input. It is instantiated WIDTH times via generate.
- The prescaler, pending mask, priority encoder and overflow logic stay in btn_debounce.

Test Plan:
All tests use WIDTH=16, TICK_DIV=4, STABLE_TICKS=3. The level-change window is 11..14 cycles after a raw change.
1. Hold rst=1 for 3 cycles with raw_in=16'hFFFF, then release -> level=0, evt_valid=0 and overflow=0 during reset. level becomes 16'hFFFF 11..14 cycles after release, with rise=16'hFFFF for exactly 1 cycle. evt_idx=0.
2. Toggle raw_in[0] every 3 cycles for 60 cycles, ending at 0 -> level[0], rise[0] and fall[0] stay 0 throughout; evt_valid=0.
3. Hold raw_in[3]=1 with evt_ready=0 -> level[3]=1 within 11..14 cycles, rise[3] pulses 1 cycle, then evt_valid=1 and evt_idx=3. Then release raw_in[3] -> fall[3] pulses 1 cycle and the pending state is unchanged.
4. Press channels 2 and 7 on the same cycle with evt_ready=0 -> evt_idx=2. Pulse evt_ready for 1 cycle -> evt_idx=7. Pulse evt_ready again -> evt_valid=0.
5. With evt_ready=0, press, release and re-press channel 5 -> one pending event at idx 5 and overflow=1. Pulse ovf_clr -> overflow=0 and the event is still pending.
6. Time the evt_ready pop of pend[5] to coincide with a new rise[5] -> evt_valid stays 1, evt_idx=5, overflow stays 0.
